// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared definitions for the instruction-side SRAM controller.
//               Holds the controller state encoding, the SRAM idle byte-enable
//               level, the default access wait count and the byte-to-word
//               address slice constants.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DREAD   = 3'd2,
        ST_WSETUP  = 3'd3,
        ST_WSTROBE = 3'd4,
        ST_WHOLD   = 3'd5,
        ST_DONE    = 3'd6
    } sram_state_e;

    // Byte enables are active low; all ones means no byte lane selected
    localparam logic [3:0] SRAM_IDLE_BE_N = 4'hF;

    // SRAM access cycles per read or write strobe
    localparam int DEFAULT_WAIT_CYCLES = 1;

    // Word address lives in byte-address bits [21:2] for a 20-bit SRAM
    localparam int WORD_ADDR_LSB = 2;
    localparam int WORD_ADDR_MSB = 21;

    // Width of the shared wait counter (covers WAIT_CYCLES 1..15)
    localparam int WAIT_CNT_W = 4;

endpackage : sram_pkg
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : sram_wait_counter
// Description : Loadable down-counter timing SRAM access phases. Loaded on
//               entry to an access state, decremented once per cycle while the
//               access is in progress. Saturates at zero.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               load_i        - load load_val_i (has priority over dec_i)
//               dec_i         - decrement by one
//               load_val_i    - value loaded on load_i
//               zero_o        - count is zero
//               last_o        - count is one: the current cycle is the final
//                               cycle of the access
// Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_counter
    import sram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  dec_i,
    input  logic [WAIT_CNT_W-1:0] load_val_i,
    output logic                  zero_o,
    output logic                  last_o
);

    logic [WAIT_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == {{(WAIT_CNT_W-1){1'b0}}, 1'b1});

endmodule : sram_wait_counter
`default_nettype wire

// File: rtl/im_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : im_sram_ctrl
// Description : Instruction-side controller for the external base SRAM. Turns
//               fetch addresses into word reads, holds the last fetched word so
//               repeated fetches of it cost no SRAM traffic, and arbitrates a
//               MEM-stage request/ack port that has priority over fetch.
// Ports       : clk, rst              - clock, asynchronous active-high reset
//               im_addr / im_data     - fetch byte address / registered word
//               fetch_stall           - high while im_data != word at im_addr
//               dm_req/dm_we/dm_addr/dm_wdata/dm_be - MEM-stage request
//               dm_rdata / dm_ack     - registered read data / done pulse
//               sram_addr, sram_data_i, sram_data_o, sram_data_oe,
//               sram_ce_n, sram_oe_n, sram_we_n, sram_be_n - SRAM pins
// Revision    : 1.0 - initial release
// ============================================================================
module im_sram_ctrl
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int SRAM_AW     = WORD_ADDR_MSB - WORD_ADDR_LSB + 1
) (
    input  logic               clk,
    input  logic               rst,
    // fetch side
    input  logic [31:0]        im_addr,
    output logic [31:0]        im_data,
    output logic               fetch_stall,
    // MEM-stage side
    input  logic               dm_req,
    input  logic               dm_we,
    input  logic [31:0]        dm_addr,
    input  logic [31:0]        dm_wdata,
    input  logic [3:0]         dm_be,
    output logic [31:0]        dm_rdata,
    output logic               dm_ack,
    // SRAM pins
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [31:0]        sram_data_i,
    output logic [31:0]        sram_data_o,
    output logic               sram_data_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [3:0]         sram_be_n
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    sram_state_e        state_q;
    logic [29:0]        fetch_addr_q;
    logic [29:0]        fetched_addr_q;
    logic               fetched_valid_q;
    logic [31:0]        im_data_q;
    logic [31:0]        dm_rdata_q;
    logic               dm_ack_q;
    logic [SRAM_AW-1:0] sram_addr_q;
    logic [31:0]        sram_data_o_q;
    logic               sram_data_oe_q;
    logic               sram_ce_n_q;
    logic               sram_oe_n_q;
    logic               sram_we_n_q;
    logic [3:0]         sram_be_n_q;

    logic               hit;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_zero;
    logic               cnt_last;
    logic               cnt_done;
    logic               w_unused;

    // Byte-offset bits never select anything: every access is a full word slot
    assign w_unused = ^{im_addr[1:0], dm_addr[1:0]};

    assign hit         = fetched_valid_q && (im_addr[31:2] == fetched_addr_q);
    assign fetch_stall = !hit;

    // Counter is loaded on the edge that enters a timed state (FETCH, DREAD
    // from IDLE; WSTROBE from WSETUP) and runs down while in that state.
    assign cnt_load = ((state_q == ST_IDLE) &&
                       ((dm_req && !dm_we) || (!dm_req && !hit))) ||
                      (state_q == ST_WSETUP);
    assign cnt_dec  = (state_q == ST_FETCH) || (state_q == ST_DREAD) ||
                      (state_q == ST_WSTROBE);
    // zero only matters if the counter were ever entered empty; it keeps the
    // FSM from hanging in that case
    assign cnt_done = cnt_last || cnt_zero;

    sram_wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (WAIT_LOAD),
        .zero_o     (cnt_zero),
        .last_o     (cnt_last)
    );

    // All SRAM pins are registered and set on the edge that enters a state,
    // so they are glitch-free and already valid during that state's cycles.
    // Reset returns the strobes to idle asynchronously, which aborts an
    // in-flight write immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            fetch_addr_q    <= '0;
            fetched_addr_q  <= '0;
            fetched_valid_q <= 1'b0;
            im_data_q       <= '0;
            dm_rdata_q      <= '0;
            dm_ack_q        <= 1'b0;
            sram_addr_q     <= '0;
            sram_data_o_q   <= '0;
            sram_data_oe_q  <= 1'b0;
            sram_ce_n_q     <= 1'b1;
            sram_oe_n_q     <= 1'b1;
            sram_we_n_q     <= 1'b1;
            sram_be_n_q     <= SRAM_IDLE_BE_N;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dm_req) begin
                        // data access wins over any pending fetch miss
                        sram_addr_q <= dm_addr[WORD_ADDR_LSB +: SRAM_AW];
                        sram_ce_n_q <= 1'b0;
                        sram_be_n_q <= ~dm_be;
                        if (!dm_we) begin
                            sram_oe_n_q <= 1'b0;
                            state_q     <= ST_DREAD;
                        end else begin
                            sram_data_o_q  <= dm_wdata;
                            sram_data_oe_q <= 1'b1;
                            state_q        <= ST_WSETUP;
                        end
                    end else if (!hit) begin
                        fetch_addr_q <= im_addr[31:2];
                        sram_addr_q  <= im_addr[WORD_ADDR_LSB +: SRAM_AW];
                        sram_ce_n_q  <= 1'b0;
                        sram_oe_n_q  <= 1'b0;
                        sram_be_n_q  <= 4'h0;
                        state_q      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Installed even if im_addr moved meanwhile; the hit check
                    // then fails and a fresh fetch follows.
                    if (cnt_done) begin
                        im_data_q       <= sram_data_i;
                        fetched_addr_q  <= fetch_addr_q;
                        fetched_valid_q <= 1'b1;
                        sram_ce_n_q     <= 1'b1;
                        sram_oe_n_q     <= 1'b1;
                        sram_be_n_q     <= SRAM_IDLE_BE_N;
                        state_q         <= ST_IDLE;
                    end
                end
                ST_DREAD: begin
                    if (cnt_done) begin
                        dm_rdata_q  <= sram_data_i;
                        dm_ack_q    <= 1'b1;
                        sram_ce_n_q <= 1'b1;
                        sram_oe_n_q <= 1'b1;
                        sram_be_n_q <= SRAM_IDLE_BE_N;
                        state_q     <= ST_DONE;
                    end
                end
                ST_WSETUP: begin
                    sram_we_n_q <= 1'b0;
                    state_q     <= ST_WSTROBE;
                end
                ST_WSTROBE: begin
                    if (cnt_done) begin
                        sram_we_n_q <= 1'b1;
                        state_q     <= ST_WHOLD;
                    end
                end
                ST_WHOLD: begin
                    // keep the held instruction word coherent with the SRAM
                    if (dm_addr[31:2] == fetched_addr_q) begin
                        fetched_valid_q <= 1'b0;
                    end
                    dm_ack_q       <= 1'b1;
                    sram_data_oe_q <= 1'b0;
                    sram_ce_n_q    <= 1'b1;
                    sram_be_n_q    <= SRAM_IDLE_BE_N;
                    state_q        <= ST_DONE;
                end
                ST_DONE: begin
                    dm_ack_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign im_data      = im_data_q;
    assign dm_rdata     = dm_rdata_q;
    assign dm_ack       = dm_ack_q;
    assign sram_addr    = sram_addr_q;
    assign sram_data_o  = sram_data_o_q;
    assign sram_data_oe = sram_data_oe_q;
    assign sram_ce_n    = sram_ce_n_q;
    assign sram_oe_n    = sram_oe_n_q;
    assign sram_we_n    = sram_we_n_q;
    assign sram_be_n    = sram_be_n_q;

endmodule : im_sram_ctrl
`default_nettype wire

// File: tb/tb_im_sram_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_im_sram_ctrl
// Description : Directed self-checking bench for im_sram_ctrl. Instance u_dut0
//               runs with WAIT_CYCLES = 1, u_dut1 with WAIT_CYCLES = 3; each
//               has its own small behavioural SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic preload;

    // ---------------- instance 0 (WAIT_CYCLES = 1) ----------------
    logic        rst0, stall0, dm_req0, dm_we0, dm_ack0;
    logic [31:0] im_addr0, im_data0, dm_addr0, dm_wdata0, dm_rdata0, rd0, wd0;
    logic [3:0]  dm_be0, be_n0;
    logic [19:0] sa0;
    logic        doe0, ce_n0, oe_n0, we_n0;
    logic [31:0] mem0 [256];

    im_sram_ctrl #(.WAIT_CYCLES(1), .SRAM_AW(20)) u_dut0 (
        .clk(clk), .rst(rst0), .im_addr(im_addr0), .im_data(im_data0),
        .fetch_stall(stall0), .dm_req(dm_req0), .dm_we(dm_we0),
        .dm_addr(dm_addr0), .dm_wdata(dm_wdata0), .dm_be(dm_be0),
        .dm_rdata(dm_rdata0), .dm_ack(dm_ack0), .sram_addr(sa0),
        .sram_data_i(rd0), .sram_data_o(wd0), .sram_data_oe(doe0),
        .sram_ce_n(ce_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0),
        .sram_be_n(be_n0)
    );

    // ---------------- instance 1 (WAIT_CYCLES = 3) ----------------
    logic        rst1, stall1, dm_req1, dm_we1, dm_ack1;
    logic [31:0] im_addr1, im_data1, dm_addr1, dm_wdata1, dm_rdata1, rd1, wd1;
    logic [3:0]  dm_be1, be_n1;
    logic [19:0] sa1;
    logic        doe1, ce_n1, oe_n1, we_n1;
    logic [31:0] mem1 [256];

    im_sram_ctrl #(.WAIT_CYCLES(3), .SRAM_AW(20)) u_dut1 (
        .clk(clk), .rst(rst1), .im_addr(im_addr1), .im_data(im_data1),
        .fetch_stall(stall1), .dm_req(dm_req1), .dm_we(dm_we1),
        .dm_addr(dm_addr1), .dm_wdata(dm_wdata1), .dm_be(dm_be1),
        .dm_rdata(dm_rdata1), .dm_ack(dm_ack1), .sram_addr(sa1),
        .sram_data_i(rd1), .sram_data_o(wd1), .sram_data_oe(doe1),
        .sram_ce_n(ce_n1), .sram_oe_n(oe_n1), .sram_we_n(we_n1),
        .sram_be_n(be_n1)
    );

    // ---------------- behavioural SRAMs ----------------
    assign rd0 = mem0[sa0[7:0]];
    assign rd1 = mem1[sa1[7:0]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= 32'h0;
                mem1[i] <= 32'h0;
            end
            mem0[0] <= 32'h3C01_1234;
            mem0[1] <= 32'h2402_0005;
            mem0[4] <= 32'hCAFE_F00D;
            mem1[0] <= 32'h1111_1111;
            mem1[2] <= 32'h2222_2222;
        end else begin
            if (!ce_n0 && !we_n0 && doe0)
                for (int b = 0; b < 4; b++)
                    if (!be_n0[b]) mem0[sa0[7:0]][b*8 +: 8] <= wd0[b*8 +: 8];
            if (!ce_n1 && !we_n1 && doe1)
                for (int b = 0; b < 4; b++)
                    if (!be_n1[b]) mem1[sa1[7:0]][b*8 +: 8] <= wd1[b*8 +: 8];
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; preload = 1'b1;
        im_addr0 = 32'h8000_0000; dm_req0 = 1'b0; dm_we0 = 1'b0;
        dm_addr0 = '0; dm_wdata0 = '0; dm_be0 = '0;
        im_addr1 = 32'h8000_0000; dm_req1 = 1'b0; dm_we1 = 1'b0;
        dm_addr1 = '0; dm_wdata1 = '0; dm_be1 = '0;
        repeat (3) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        n_cmp++; if (stall0 !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b want 1", stall0); end
        n_cmp++; if (ce_n0 !== 1'b1) begin n_fail++; $display("FAIL reset_ce_n: got %b want 1", ce_n0); end
        n_cmp++; if ({oe_n0, we_n0, doe0} !== 3'b110) begin n_fail++; $display("FAIL reset_strobes: oe/we/oe_data got %b want 110", {oe_n0, we_n0, doe0}); end
        n_cmp++; if (be_n0 !== 4'hF) begin n_fail++; $display("FAIL reset_be_n: got %h want f", be_n0); end
        n_cmp++; if ({im_data0, dm_rdata0, 12'h0, sa0} !== 96'h0) begin n_fail++; $display("FAIL reset_data: im %h dm %h addr %h want 0", im_data0, dm_rdata0, sa0); end
        n_cmp++; if (dm_ack0 !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", dm_ack0); end
    endtask

    task automatic test_fetch_miss();
        int n;
        @(posedge clk);
        #1 rst0 = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall0) break;
            n++;
        end
        n_cmp++; if (n != 2) begin n_fail++; $display("FAIL miss_stall_cycles: got %0d want 2", n); end
        n_cmp++; if (im_data0 !== 32'h3C01_1234) begin n_fail++; $display("FAIL miss_im_data: got %h want 3c011234", im_data0); end
        n_cmp++; if (sa0 !== 20'h0) begin n_fail++; $display("FAIL miss_sram_addr: got %h want 0", sa0); end
    endtask

    task automatic test_hit_hold();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL hit_stall[%0d]: got %b want 0", i, stall0); end
            n_cmp++; if (ce_n0 !== 1'b1) begin n_fail++; $display("FAIL hit_ce_n[%0d]: got %b want 1", i, ce_n0); end
        end
    endtask

    task automatic test_dm_priority();
        int n;
        logic [19:0] a2;
        logic oe2, st_ack;
        @(posedge clk);
        #1;
        im_addr0 = 32'h8000_0004;
        dm_req0 = 1'b1; dm_we0 = 1'b0; dm_addr0 = 32'h8000_0010; dm_be0 = 4'hF;
        n = 0; a2 = '1; oe2 = 1'b1; st_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (n == 2) begin a2 = sa0; oe2 = oe_n0; end
            if (dm_ack0) begin st_ack = stall0; break; end
        end
        n_cmp++; if (n != 3) begin n_fail++; $display("FAIL read_ack_latency: got %0d want 3", n); end
        n_cmp++; if (dm_rdata0 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL read_rdata: got %h want cafef00d", dm_rdata0); end
        n_cmp++; if ({a2, oe2} !== {20'h4, 1'b0}) begin n_fail++; $display("FAIL read_first_addr: got %h oe_n %b want 4 oe_n 0", a2, oe2); end
        n_cmp++; if (st_ack !== 1'b1) begin n_fail++; $display("FAIL read_stall_at_ack: got %b want 1", st_ack); end
        @(posedge clk);
        #1 dm_req0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall0) break;
        end
        n_cmp++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL refetch_done: stall got %b want 0", stall0); end
        n_cmp++; if (im_data0 !== 32'h2402_0005) begin n_fail++; $display("FAIL refetch_im_data: got %h want 24020005", im_data0); end
    endtask

    task automatic test_write_snoop();
        int n, we_low;
        logic [3:0] be2;
        logic doe2, st_ack;
        @(posedge clk);
        #1;
        dm_req0 = 1'b1; dm_we0 = 1'b1; dm_addr0 = 32'h8000_0004;
        dm_wdata0 = 32'hDEAD_BEEF; dm_be0 = 4'b0011;
        n = 0; we_low = 0; be2 = '0; doe2 = 1'b0; st_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (!we_n0) we_low++;
            if (n == 2) begin be2 = be_n0; doe2 = doe0; end
            if (dm_ack0) begin st_ack = stall0; break; end
        end
        n_cmp++; if (n != 5) begin n_fail++; $display("FAIL write_ack_latency: got %0d want 5", n); end
        n_cmp++; if (we_low != 1) begin n_fail++; $display("FAIL write_we_low_cycles: got %0d want 1", we_low); end
        n_cmp++; if ({be2, doe2} !== {4'b1100, 1'b1}) begin n_fail++; $display("FAIL write_be_n: got %b oe_data %b want 1100 1", be2, doe2); end
        n_cmp++; if (st_ack !== 1'b1) begin n_fail++; $display("FAIL write_snoop_stall: got %b want 1", st_ack); end
        @(posedge clk);
        #1 dm_req0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall0) break;
        end
        n_cmp++; if (im_data0 !== 32'h2402_BEEF) begin n_fail++; $display("FAIL snoop_refetch_data: got %h want 2402beef (stall %b)", im_data0, stall0); end
    endtask

    task automatic test_reset_mid_write();
        logic ack_seen;
        @(posedge clk);
        #1;
        dm_req0 = 1'b1; dm_we0 = 1'b1; dm_addr0 = 32'h8000_0040;
        dm_wdata0 = 32'h1234_5678; dm_be0 = 4'hF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!we_n0) break;
        end
        n_cmp++; if (we_n0 !== 1'b0) begin n_fail++; $display("FAIL abort_strobe_reached: we_n got %b want 0", we_n0); end
        rst0 = 1'b1;
        #1;
        n_cmp++; if ({we_n0, ce_n0, doe0} !== 3'b110) begin n_fail++; $display("FAIL abort_async_idle: we/ce/oe_data got %b want 110", {we_n0, ce_n0, doe0}); end
        dm_req0 = 1'b0;
        @(posedge clk);
        #1 rst0 = 1'b0;
        ack_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dm_ack0) ack_seen = 1'b1;
        end
        n_cmp++; if (ack_seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_ack: got %b want 0", ack_seen); end
        n_cmp++; if (mem0[16] !== 32'h0) begin n_fail++; $display("FAIL abort_no_write: mem got %h want 0", mem0[16]); end
    endtask

    task automatic test_wait3();
        int n, we_low;
        @(posedge clk);
        #1 rst1 = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall1) break;
            n++;
        end
        n_cmp++; if (n != 4) begin n_fail++; $display("FAIL w3_miss_stall: got %0d want 4", n); end
        n_cmp++; if (im_data1 !== 32'h1111_1111) begin n_fail++; $display("FAIL w3_im_data: got %h want 11111111", im_data1); end
        // read
        @(posedge clk);
        #1;
        dm_req1 = 1'b1; dm_we1 = 1'b0; dm_addr1 = 32'h8000_0008; dm_be1 = 4'hF;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n++;
            if (dm_ack1) break;
        end
        n_cmp++; if (n != 5) begin n_fail++; $display("FAIL w3_read_latency: got %0d want 5", n); end
        n_cmp++; if (dm_rdata1 !== 32'h2222_2222) begin n_fail++; $display("FAIL w3_read_data: got %h want 22222222", dm_rdata1); end
        @(posedge clk);
        #1 dm_req1 = 1'b0;
        // write
        @(posedge clk);
        #1;
        dm_req1 = 1'b1; dm_we1 = 1'b1; dm_addr1 = 32'h8000_000C;
        dm_wdata1 = 32'hA5A5_A5A5; dm_be1 = 4'hF;
        n = 0; we_low = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n++;
            if (!we_n1) we_low++;
            if (dm_ack1) break;
        end
        n_cmp++; if (n != 7) begin n_fail++; $display("FAIL w3_write_latency: got %0d want 7", n); end
        n_cmp++; if (we_low != 3) begin n_fail++; $display("FAIL w3_we_low_cycles: got %0d want 3", we_low); end
        @(posedge clk);
        #1 dm_req1 = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem1[3] !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL w3_write_mem: got %h want a5a5a5a5", mem1[3]); end
        n_cmp++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL w3_hit_kept: stall got %b want 0", stall1); end
    endtask

    initial begin
        test_reset();
        test_fetch_miss();
        test_hit_hold();
        test_dm_priority();
        test_write_snoop();
        test_reset_mid_write();
        test_wait3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_im_sram_ctrl
`default_nettype wire
